weight_stream_reader: RTL and testbench
=======================================

Name: weight_stream_reader

Overview:
- Read-side sequencer for one per-neuron weight BRAM. The BRAM holds 28 x 16-bit words, has a single port, clocks on negedge, and returns a registered DO when EN=1 and WE=0.
- On START, the block walks addresses 0..DEPTH-1, captures each DO word, and presents it on a valid/ready stream to the MAC datapath. It carries W_INDEX and W_LAST alongside each word.
- It sits between the weight BRAM and the neuron accumulator. It never writes the BRAM.

Parameters:
- DEPTH, 28, number of weight words per neuron (BRAM entries 0..DEPTH-1)
- ADDR_W, 5, BRAM address width; must satisfy 2^ADDR_W >= DEPTH
- DATA_W, 16, weight word width (fixed-point as stored)

Ports:
- CLK  in  1  system clock; all block state on posedge
- RST_N  in  1  asynchronous active-low reset
- START  in  1  single-cycle pulse that begins one pass; ignored unless state is IDLE
- BUSY  out  1  high from the cycle after an accepted START until DONE
- DONE  out  1  single-cycle pulse after the last word is accepted downstream
- BRAM_ADDR  out  ADDR_W  address to the BRAM ADDR port
- BRAM_EN  out  1  BRAM enable; high only in cycles that issue a read
- BRAM_WE  out  1  constant 0
- BRAM_DO  in  DATA_W  BRAM read data
- W_DATA  out  DATA_W  weight word
- W_INDEX  out  ADDR_W  address the word was read from
- W_LAST  out  1  high with the word whose index is DEPTH-1
- W_VALID  out  1  stream valid
- W_READY  in  1  stream ready; transfer happens when W_VALID and W_READY are both high at posedge
- CHECKSUM  out  DATA_W  present only with the optional feature

Behaviour:
- Reset (RST_N=0, async): state IDLE; BRAM_EN=0, BRAM_ADDR=0, BRAM_WE=0; W_VALID=0, W_DATA=0, W_INDEX=0, W_LAST=0; BUSY=0, DONE=0; FIFO and in-flight flag cleared. Reset mid-pass abandons the pass; no DONE is emitted.
- Read timing:
  - BRAM_EN and BRAM_ADDR are registered at posedge N.
  - The BRAM samples them at negedge N.
  - BRAM_DO is captured at posedge N+1 into a 2-entry output FIFO, together with the issued address.
  - Read latency is 1 cycle from issue to FIFO write. An in-flight flag tracks the outstanding read.
- Credit rule: a read issues in a cycle only if FIFO occupancy + in-flight + (pop this cycle ? -1 : 0) < 2. BRAM_EN is 0 in every cycle that does not issue.
- FSM:
  - IDLE --START--> FETCH. The read address counter is set to 0.
  - FETCH: issue reads per the credit rule, incrementing the address. After issuing address DEPTH-1 -> DRAIN.
  - DRAIN: no issue. When the FIFO is empty, in-flight=0, and the last word (W_LAST) has been transferred -> FIN.
  - FIN: DONE=1 for one cycle -> IDLE.
- Stream output:
  - W_DATA, W_INDEX, W_LAST and W_VALID come from the FIFO head. W_VALID equals "FIFO not empty".
  - Held stable while W_VALID=1 and W_READY=0.
  - Zero bubbles at steady state when W_READY=1: one word per cycle.
- Boundary cases:
  - Address never exceeds DEPTH-1; no wrap.
  - Push and pop in the same cycle on a full FIFO is legal because the credit rule reserves space.
  - START while BUSY or in FIN is ignored.
  - START in the same cycle as DONE is ignored; it is accepted from IDLE on the next cycle.
- Latency: START at cycle 0 -> first W_VALID at cycle 3 (idle->FETCH, issue, capture).
- Total pass with W_READY=1: last transfer at cycle DEPTH+2 and DONE at cycle DEPTH+3.

Optional Feature:
- Macro: WEIGHT_STREAM_CHECKSUM_EN.
- Defined:
  - CHECKSUM port exists. It is a modulo-2^DATA_W sum of every transferred W_DATA in the current pass.
  - Cleared to 0 on reset and on an accepted START.
  - Holds its final value from DONE until the next START.
- Undefined: the port and the accumulator logic are absent; all other behaviour is identical.

Decomposition:
- Package weight_stream_pkg holds:
  - DEPTH/ADDR_W/DATA_W defaults
  - state enum {IDLE, FETCH, DRAIN, FIN}
  - FIFO entry struct {data, index, last}
- Sub-module weight_skid_fifo: 2-entry synchronous FIFO with push/pop/full/empty/head outputs and the same async active-low reset.

Test Plan:
- BRAM model loaded with word i = 16'h0100+i, START, W_READY=1 -> 28 transfers with W_DATA 16'h0100..16'h011B and W_INDEX 0..27 in order. W_LAST only on index 27. First W_VALID at cycle 3; DONE at cycle 31.
- W_READY toggling 1,0,0,1 repeating -> same 28 words, no loss or duplication, outputs stable while stalled. BRAM_EN never issues with FIFO occupancy + in-flight = 2.
- W_READY held 0 after START for 20 cycles -> exactly 2 words buffered, BRAM_EN=0 thereafter. BRAM_ADDR last issued = 1; BUSY=1, DONE=0.
- Second START pulsed at word 10 of a pass -> ignored; exactly 28 words and one DONE. START one cycle after DONE -> new pass, index restarts at 0.
- RST_N asserted asynchronously at word 15 -> all outputs 0 immediately, no DONE. A fresh START then yields the full 28-word pass.
- With WEIGHT_STREAM_CHECKSUM_EN, data 16'h0100+i -> CHECKSUM = 16'h1D7A at DONE (sum of 16'h0100..16'h011B). It returns to 0 on the next START.

Source files
------------

// File: rtl/weight_stream_pkg.sv
// Shared definitions for the weight stream reader.
//   DefaultDepth/DefaultAddrW/DefaultDataW : default geometry of one per-neuron weight BRAM
//   ws_state_e                             : sequencer states
//   w_entry_t                              : one buffered word with its address and last flag
package weight_stream_pkg;

  localparam int unsigned DefaultDepth = 28;
  localparam int unsigned DefaultAddrW = 5;
  localparam int unsigned DefaultDataW = 16;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StDrain,
    StFin
  } ws_state_e;

  typedef struct packed {
    logic [DefaultDataW-1:0] data;
    logic [DefaultAddrW-1:0] index;
    logic                    last;
  } w_entry_t;

endpackage

// File: rtl/weight_skid_fifo.sv
// Two-entry synchronous FIFO holding weight words between BRAM capture and the stream port.
//   clk_i, rst_ni : clock, asynchronous active-low reset (clears storage and pointers)
//   push_i        : write entry_i (accepted when not full, or when full and popping)
//   pop_i         : remove the head entry (ignored when empty)
//   full_o        : both entries occupied
//   empty_o       : no entry occupied
//   head_o        : oldest entry; all-zero after reset
module weight_skid_fifo
  import weight_stream_pkg::*;
(
  input  logic     clk_i,
  input  logic     rst_ni,
  input  logic     push_i,
  input  w_entry_t entry_i,
  input  logic     pop_i,
  output logic     full_o,
  output logic     empty_o,
  output w_entry_t head_o
);

  w_entry_t   mem_q [2];
  w_entry_t   mem_d [2];
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] count_q, count_d;
  logic       do_push, do_pop;

  always_comb begin
    do_pop   = pop_i && (count_q != 2'd0);
    // A push into a full FIFO is fine when the head leaves in the same cycle.
    do_push  = push_i && ((count_q != 2'd2) || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = entry_i;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign full_o  = (count_q == 2'd2);
  assign empty_o = (count_q == 2'd0);
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/weight_stream_reader.sv
// Read-side sequencer for one per-neuron weight BRAM (negedge-clocked, registered DO).
// On START it reads addresses 0..DEPTH-1 and streams each word, with its index and a
// last flag, on a valid/ready port towards the MAC datapath. The BRAM is never written.
//   CLK, RST_N           : clock (posedge), asynchronous active-low reset
//   START                : one-cycle pulse, accepted only in idle
//   BUSY, DONE           : pass in progress / one-cycle end-of-pass pulse
//   BRAM_ADDR/EN/WE/DO   : BRAM read port (WE tied low)
//   W_DATA/INDEX/LAST    : stream payload taken from the FIFO head
//   W_VALID, W_READY     : stream handshake
//   CHECKSUM             : running sum of transferred words, only when
//                          WEIGHT_STREAM_CHECKSUM_EN is defined
// ADDR_W and DATA_W must match the package widths that size w_entry_t.
module weight_stream_reader
  import weight_stream_pkg::*;
#(
  parameter int unsigned DEPTH  = DefaultDepth,
  parameter int unsigned ADDR_W = DefaultAddrW,
  parameter int unsigned DATA_W = DefaultDataW
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              START,
  output logic              BUSY,
  output logic              DONE,
  output logic [ADDR_W-1:0] BRAM_ADDR,
  output logic              BRAM_EN,
  output logic              BRAM_WE,
  input  logic [DATA_W-1:0] BRAM_DO,
  output logic [DATA_W-1:0] W_DATA,
  output logic [ADDR_W-1:0] W_INDEX,
  output logic              W_LAST,
  output logic              W_VALID,
  input  logic              W_READY
`ifdef WEIGHT_STREAM_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] CHECKSUM
`endif
);

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

  ws_state_e         state_q, state_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0] bram_addr_q, bram_addr_d;
  logic              bram_en_q, bram_en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              fifo_full, fifo_empty;
  logic              pop, credit_ok;
  logic [1:0]        occupancy, credit_used;
  w_entry_t          push_entry, head;
`ifdef WEIGHT_STREAM_CHECKSUM_EN
  logic [DATA_W-1:0] csum_q, csum_d;
`endif

  // A read issued last cycle (BRAM_EN high now) is the in-flight word; it lands this edge.
  assign push_entry = '{data: BRAM_DO, index: bram_addr_q, last: (bram_addr_q == LastAddr)};

  weight_skid_fifo u_fifo (
    .clk_i   (CLK),
    .rst_ni  (RST_N),
    .push_i  (bram_en_q),
    .entry_i (push_entry),
    .pop_i   (pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (head)
  );

  assign pop         = !fifo_empty && W_READY;
  assign occupancy   = fifo_full ? 2'd2 : {1'b0, !fifo_empty};
  // Occupancy plus in-flight never exceeds 2, so the 2-bit sum cannot wrap.
  assign credit_used = occupancy + {1'b0, bram_en_q} - {1'b0, pop};
  assign credit_ok   = (credit_used < 2'd2);

  always_comb begin
    state_d     = state_q;
    rd_ptr_d    = rd_ptr_q;
    bram_addr_d = bram_addr_q;
    bram_en_d   = 1'b0;
`ifdef WEIGHT_STREAM_CHECKSUM_EN
    csum_d      = pop ? (csum_q + head.data) : csum_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (START) begin
          state_d  = StFetch;
          rd_ptr_d = '0;
`ifdef WEIGHT_STREAM_CHECKSUM_EN
          csum_d   = '0;
`endif
        end
      end
      StFetch: begin
        if (credit_ok) begin
          bram_en_d   = 1'b1;
          bram_addr_d = rd_ptr_q;
          if (rd_ptr_q == LastAddr) begin
            state_d = StDrain;
          end else begin
            rd_ptr_d = rd_ptr_q + 1'b1;
          end
        end
      end
      StDrain: begin
        // Finishing as the last word leaves lets DONE follow the final transfer directly.
        if (pop && head.last && (occupancy == 2'd1) && !bram_en_q) begin
          state_d = StFin;
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    busy_d = (state_d == StFetch) || (state_d == StDrain);
    done_d = (state_d == StFin);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= StIdle;
      rd_ptr_q    <= '0;
      bram_addr_q <= '0;
      bram_en_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef WEIGHT_STREAM_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      rd_ptr_q    <= rd_ptr_d;
      bram_addr_q <= bram_addr_d;
      bram_en_q   <= bram_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef WEIGHT_STREAM_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign BRAM_EN   = bram_en_q;
  assign BRAM_ADDR = bram_addr_q;
  assign BRAM_WE   = 1'b0;
  assign W_VALID   = !fifo_empty;
  assign W_DATA    = head.data;
  assign W_INDEX   = head.index;
  assign W_LAST    = head.last;
`ifdef WEIGHT_STREAM_CHECKSUM_EN
  assign CHECKSUM  = csum_q;
`endif

endmodule

// File: tb/tb_weight_stream_reader.sv
// Self-checking bench for weight_stream_reader: a negedge BRAM model feeds the DUT, and
// every pass is compared against the expected word list mem[0..27] and the stated timing.
module tb_weight_stream_reader;

  localparam int Depth = 28;
  localparam int AddrW = 5;
  localparam int DataW = 16;

  logic             clk = 1'b0;
  logic             rst_n, start, w_ready;
  logic             busy, done, bram_en, bram_we, w_last, w_valid;
  logic [AddrW-1:0] bram_addr, w_index;
  logic [DataW-1:0] bram_do = '0;
  logic [DataW-1:0] w_data;
`ifdef WEIGHT_STREAM_CHECKSUM_EN
  logic [DataW-1:0] checksum;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  weight_stream_reader dut (
    .CLK       (clk),
    .RST_N     (rst_n),
    .START     (start),
    .BUSY      (busy),
    .DONE      (done),
    .BRAM_ADDR (bram_addr),
    .BRAM_EN   (bram_en),
    .BRAM_WE   (bram_we),
    .BRAM_DO   (bram_do),
    .W_DATA    (w_data),
    .W_INDEX   (w_index),
    .W_LAST    (w_last),
    .W_VALID   (w_valid),
    .W_READY   (w_ready)
`ifdef WEIGHT_STREAM_CHECKSUM_EN
    ,
    .CHECKSUM  (checksum)
`endif
  );

  // BRAM model: registered read on negedge when enabled and not writing.
  logic [DataW-1:0] mem [Depth];
  always @(negedge clk) begin
    if (bram_en && !bram_we && int'(bram_addr) < Depth) bram_do <= mem[bram_addr];
  end

  // Observations of one pass, filled by run_pass and judged by the test tasks.
  logic [DataW-1:0] obs_data[$];
  int               obs_index[$];
  logic             obs_last[$];
  int               first_valid_cyc, last_xfer_cyc, done_cyc, issue_cnt;
  int               addr_err, credit_err, stall_err, busy_err;
  bit               timed_out;
  logic [DataW-1:0] csum_done, csum_c1;

  function automatic logic ready_for(input int mode, input int k);
    case (mode)
      0:       return 1'b1;
      1:       return (((k - 1) % 4) == 0) || (((k - 1) % 4) == 3);
      2:       return 1'($urandom_range(0, 1));
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [DataW-1:0] model_sum();
    logic [DataW-1:0] s = '0;
    for (int i = 0; i < Depth; i++) s = s + mem[i];
    return s;
  endfunction

  task automatic fill_mem(input bit ramp);
    for (int i = 0; i < Depth; i++) mem[i] = ramp ? DataW'(16'h0100 + i) : DataW'($urandom);
  endtask

  // Drives one pass from a negedge; returns at the negedge of the DONE cycle, or when
  // abort_word words have been transferred. Cycle 0 is the cycle START is high.
  task automatic run_pass(input int mode, input int restart_word, input int abort_word);
    int               k;
    bit               prev_stall, restarted;
    logic [DataW-1:0] pd;
    logic [AddrW-1:0] pi;
    logic             pl;
    obs_data.delete(); obs_index.delete(); obs_last.delete();
    first_valid_cyc = -1; last_xfer_cyc = -1; done_cyc = -1; issue_cnt = 0;
    addr_err = 0; credit_err = 0; stall_err = 0; busy_err = 0; timed_out = 1'b1;
    csum_done = '0; csum_c1 = '1; prev_stall = 1'b0; restarted = 1'b0;
    pd = '0; pi = '0; pl = 1'b0;
    k = 0;
    start = 1'b1;
    w_ready = ready_for(mode, 0);
    while (k < 400) begin
      if (k >= 1) begin
`ifdef WEIGHT_STREAM_CHECKSUM_EN
        if (k == 1) csum_c1 = checksum;
`endif
        if (w_valid && first_valid_cyc < 0) first_valid_cyc = k;
        if (prev_stall && (w_valid !== 1'b1 || w_data !== pd || w_index !== pi || w_last !== pl))
          stall_err++;
        if (bram_en) begin
          if (int'(bram_addr) != issue_cnt) addr_err++;
          issue_cnt++;
        end
        if (w_valid && w_ready) begin
          obs_data.push_back(w_data);
          obs_index.push_back(int'(w_index));
          obs_last.push_back(w_last);
          last_xfer_cyc = k;
        end
        if (issue_cnt - obs_data.size() > 2) credit_err++;
        if (done) begin
          done_cyc = k;
`ifdef WEIGHT_STREAM_CHECKSUM_EN
          csum_done = checksum;
`endif
          timed_out = 1'b0;
          return;
        end
        if (!busy) busy_err++;
        if (abort_word >= 0 && obs_data.size() == abort_word) begin
          timed_out = 1'b0;
          return;
        end
        prev_stall = w_valid && !w_ready;
        pd = w_data; pi = w_index; pl = w_last;
      end
      @(negedge clk);
      k++;
      start = 1'b0;
      if (restart_word >= 0 && !restarted && obs_data.size() == restart_word) begin
        start = 1'b1;
        restarted = 1'b1;
      end
      w_ready = ready_for(mode, k);
    end
  endtask

  task automatic check_words(input string tag);
    logic [DataW-1:0] gd;
    int               gi;
    logic             gl;
    checks++;
    if (timed_out || obs_data.size() != Depth) begin
      errors++;
      $display("FAIL %s_count got %0d words (timeout=%0b) want %0d", tag, obs_data.size(),
               timed_out, Depth);
    end
    for (int i = 0; i < Depth; i++) begin
      gd = (i < obs_data.size()) ? obs_data[i] : 'x;
      gi = (i < obs_data.size()) ? obs_index[i] : -1;
      gl = (i < obs_data.size()) ? obs_last[i] : 1'bx;
      checks++;
      if (gd !== mem[i] || gi != i || gl !== (i == Depth - 1)) begin
        errors++;
        $display("FAIL %s_word%0d got data=%h idx=%0d last=%b want data=%h idx=%0d last=%b",
                 tag, i, gd, gi, gl, mem[i], i, (i == Depth - 1));
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; w_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bram_en, bram_we, w_valid, w_last, busy, done} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags got en=%b we=%b valid=%b last=%b busy=%b done=%b want all 0",
               bram_en, bram_we, w_valid, w_last, busy, done);
    end
    checks++;
    if (bram_addr !== '0 || w_index !== '0 || w_data !== '0) begin
      errors++;
      $display("FAIL reset_buses got addr=%h idx=%h data=%h want 0", bram_addr, w_index, w_data);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_stream_full();
    fill_mem(1'b1);
    @(negedge clk);
    run_pass(0, -1, -1);
    check_words("full");
    checks++;
    if (first_valid_cyc != 3) begin
      errors++; $display("FAIL full_first_valid got %0d want 3", first_valid_cyc);
    end
    checks++;
    if (last_xfer_cyc != Depth + 2 || done_cyc != Depth + 3) begin
      errors++;
      $display("FAIL full_timing got last=%0d done=%0d want %0d %0d", last_xfer_cyc, done_cyc,
               Depth + 2, Depth + 3);
    end
    checks++;
    if (issue_cnt != Depth || addr_err != 0 || busy_err != 0) begin
      errors++;
      $display("FAIL full_issue got issues=%0d addr_err=%0d busy_err=%0d want %0d 0 0",
               issue_cnt, addr_err, busy_err, Depth);
    end
`ifdef WEIGHT_STREAM_CHECKSUM_EN
    checks++;
    if (csum_done !== 16'h1D7A || csum_c1 !== '0) begin
      errors++;
      $display("FAIL full_checksum got done=%h start=%h want 1d7a 0000", csum_done, csum_c1);
    end
`endif
  endtask

  task automatic test_stall_pattern(input int mode, input string tag);
    fill_mem(1'b0);
    @(negedge clk);
    run_pass(mode, -1, -1);
    check_words(tag);
    checks++;
    if (stall_err != 0 || credit_err != 0) begin
      errors++;
      $display("FAIL %s_stall got unstable=%0d over_credit=%0d want 0 0", tag, stall_err,
               credit_err);
    end
    checks++;
    if (first_valid_cyc != 3 || issue_cnt != Depth || addr_err != 0) begin
      errors++;
      $display("FAIL %s_issue got first=%0d issues=%0d addr_err=%0d want 3 %0d 0", tag,
               first_valid_cyc, issue_cnt, addr_err, Depth);
    end
`ifdef WEIGHT_STREAM_CHECKSUM_EN
    checks++;
    if (csum_done !== model_sum()) begin
      errors++; $display("FAIL %s_checksum got %h want %h", tag, csum_done, model_sum());
    end
`endif
  endtask

  task automatic test_hold_ready_low();
    int issues = 0;
    int late_en = 0;
    fill_mem(1'b0);
    @(negedge clk);
    start = 1'b1; w_ready = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (bram_en) begin
        issues++;
        if (k >= 4) late_en++;
      end
    end
    checks++;
    if (issues != 2 || late_en != 0) begin
      errors++; $display("FAIL hold_issues got %0d late=%0d want 2 0", issues, late_en);
    end
    checks++;
    if (bram_addr !== AddrW'(1) || busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL hold_state got addr=%0d busy=%b done=%b want 1 1 0", bram_addr, busy, done);
    end
    checks++;
    if (w_valid !== 1'b1 || w_index !== '0 || w_data !== mem[0]) begin
      errors++;
      $display("FAIL hold_head got valid=%b idx=%0d data=%h want 1 0 %h", w_valid, w_index,
               w_data, mem[0]);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_restart();
    fill_mem(1'b0);
    @(negedge clk);
    run_pass(0, 10, -1);
    check_words("restart_a");
    checks++;
    if (done_cyc != Depth + 3) begin
      errors++; $display("FAIL restart_a_done got %0d want %0d", done_cyc, Depth + 3);
    end
    start = 1'b1;  // high during the DONE cycle: must be ignored
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL restart_ignored got busy=%b done=%b want 0 0", busy, done);
    end
    fill_mem(1'b0);
    run_pass(0, -1, -1);
    check_words("restart_b");
    checks++;
    if (first_valid_cyc != 3 || done_cyc != Depth + 3) begin
      errors++;
      $display("FAIL restart_b_timing got first=%0d done=%0d want 3 %0d", first_valid_cyc,
               done_cyc, Depth + 3);
    end
`ifdef WEIGHT_STREAM_CHECKSUM_EN
    checks++;
    if (csum_c1 !== '0 || csum_done !== model_sum()) begin
      errors++;
      $display("FAIL restart_checksum got start=%h done=%h want 0000 %h", csum_c1, csum_done,
               model_sum());
    end
`endif
  endtask

  task automatic test_async_reset();
    int dones = 0;
    fill_mem(1'b0);
    @(negedge clk);
    run_pass(0, -1, 15);
    checks++;
    if (timed_out || obs_data.size() != 15) begin
      errors++; $display("FAIL areset_reach got %0d words want 15", obs_data.size());
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bram_en, w_valid, w_last, busy, done} !== 5'b0 || bram_addr !== '0 ||
        w_index !== '0 || w_data !== '0) begin
      errors++;
      $display("FAIL areset_outputs got en=%b valid=%b last=%b busy=%b done=%b addr=%h idx=%h data=%h want 0",
               bram_en, w_valid, w_last, busy, done, bram_addr, w_index, w_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done || busy) dones++;
    end
    checks++;
    if (dones != 0) begin
      errors++; $display("FAIL areset_no_done got %0d active cycles want 0", dones);
    end
    fill_mem(1'b0);
    run_pass(0, -1, -1);
    check_words("areset_fresh");
    checks++;
    if (done_cyc != Depth + 3) begin
      errors++; $display("FAIL areset_fresh_done got %0d want %0d", done_cyc, Depth + 3);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    start = 1'b0;
    w_ready = 1'b0;
    rst_n = 1'b0;
    test_reset();
    test_stream_full();
    test_stall_pattern(1, "toggle");
    test_stall_pattern(2, "random");
    test_hold_ready_low();
    test_restart();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
